// File: rtl/seq_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : seq_bit_encoder
// Description : Sequential multi-hot encoder. Accepts a WIDTH-bit word and
//               emits the binary index of every set bit, one per output
//               handshake, flagging the final index of the word. An all-zero
//               word produces no beat, only a one-cycle zero_pulse.
//               Optional macro SEQ_ENC_MSB_FIRST_EN: scan highest bit first.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_bit_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_pulse,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [WIDTH-1:0] w_clr;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_zero;
    logic             w_zero_nxt;

    // One-hot of the index currently presented, used to retire it from the mask
    assign w_clr = WIDTH'(1) << r_idx;

    // Next-state and next-mask selection; defaults hold the current state
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_zero_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_data != '0) begin
                        w_mask_nxt  = in_data;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_zero_nxt  = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    w_mask_nxt = r_mask & ~w_clr;
                    if (r_last) begin
                        w_mask_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_mask_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pick the next index to present from the next mask (priority by scan order)
    always_comb begin
        w_idx_nxt = '0;
`ifdef SEQ_ENC_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (w_mask_nxt[i]) w_idx_nxt = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_mask_nxt[i]) w_idx_nxt = IDX_W'(i);
        end
`endif
        // Exactly one bit left means the index about to be shown is the last
        w_last_nxt = (w_mask_nxt != '0) &&
                     ((w_mask_nxt & (w_mask_nxt - WIDTH'(1))) == '0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending mask and registered output index/last/zero flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_idx  <= '0;
            r_last <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_idx  <= w_idx_nxt;
            r_last <= w_last_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_SCAN);
    assign busy       = (r_state == ST_SCAN);
    assign out_idx    = r_idx;
    assign out_last   = r_last;
    assign zero_pulse = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_bit_encoder
// Description : Directed, table-driven bench for seq_bit_encoder (WIDTH=8).
//               Expected index sequences are hand-written hex nibble lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_bit_encoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_pulse;
    logic       busy;

    int n_vec;
    int n_err;

    seq_bit_encoder #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .zero_pulse (zero_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        int          n;
        logic [31:0] nib;     // ascending indices, nibble 0 first
        bit          toggle;  // out_ready alternates 1,0,1,0...
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_at(input logic [31:0] nib, input int n, input int j);
        int k;
`ifdef SEQ_ENC_MSB_FIRST_EN
        k = n - 1 - j;
`else
        k = j;
`endif
        return nib[4*k +: 3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, then drain all its beats and check idle afterwards
    task automatic run_word(input logic [7:0] d, input int n, input logic [31:0] nib, input bit toggle);
        int j;
        int cyc;
        chk("in_ready_before", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        if (n == 0) begin
            chk("zero_pulse_hi", {31'b0, zero_pulse}, 1);
            chk("zero_no_valid", {31'b0, out_valid}, 0);
            chk("zero_in_ready", {31'b0, in_ready}, 1);
            tick();
            chk("zero_pulse_lo", {31'b0, zero_pulse}, 0);
            chk("zero_no_valid2", {31'b0, out_valid}, 0);
            return;
        end
        j   = 0;
        cyc = 0;
        while (j < n && cyc < 64) begin
            out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            // garbage offered while busy must be ignored
            in_valid  = ~out_ready;
            in_data   = 8'h5A;
            chk("beat_valid", {31'b0, out_valid}, 1);
            chk("beat_idx", {29'b0, out_idx}, {29'b0, exp_at(nib, n, j)});
            chk("beat_last", {31'b0, out_last}, (j == n - 1) ? 1 : 0);
            chk("beat_in_ready", {31'b0, in_ready}, 0);
            chk("beat_busy", {31'b0, busy}, 1);
            tick();
            if (out_ready) j++;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        if (j < n) chk("beat_timeout", j, n);
        chk("after_valid", {31'b0, out_valid}, 0);
        chk("after_in_ready", {31'b0, in_ready}, 1);
        chk("after_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        tbl[0] = '{8'h01, 1, 32'h0,        1'b0};
        tbl[1] = '{8'hA4, 3, 32'h752,      1'b0};
        tbl[2] = '{8'hFF, 8, 32'h76543210, 1'b1};
        tbl[3] = '{8'h00, 0, 32'h0,        1'b0};
        for (int i = 0; i < 8; i++) begin
            tbl[4+i] = '{8'h01 << i, 1, 32'(i), 1'b0};
        end

        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_idx", {29'b0, out_idx}, 0);
        chk("rst_out_last", {31'b0, out_last}, 0);
        chk("rst_zero_pulse", {31'b0, zero_pulse}, 0);
        chk("rst_busy", {31'b0, busy}, 0);

        for (int v = 0; v < 12; v++) begin
            run_word(tbl[v].data, tbl[v].n, tbl[v].nib, tbl[v].toggle);
            tick();
        end

        // Reset pulsed mid-scan after the first beat of 8'b1100_0000
        in_valid = 1'b1;
        in_data  = 8'hC0;
        tick();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef SEQ_ENC_MSB_FIRST_EN
        chk("mid_first_idx", {29'b0, out_idx}, 7);
`else
        chk("mid_first_idx", {29'b0, out_idx}, 6);
`endif
        chk("mid_first_last", {31'b0, out_last}, 0);
        tick();
        out_ready = 1'b0;
        chk("mid_second_valid", {31'b0, out_valid}, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_idx", {29'b0, out_idx}, 0);
        chk("mid_rst_last", {31'b0, out_last}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_zero", {31'b0, zero_pulse}, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        run_word(8'h08, 1, 32'h3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_bit_encoder.md
Name: seq_bit_encoder

Overview:
- Parametrised sequential successor to the team's 8-to-3 one-hot encoder.
- Accepts a WIDTH-bit multi-hot word and emits the binary index of every set bit, one index per output handshake, in ascending bit order.
- Marks the final index of each word.
- Sits between status/request vectors and downstream serial consumers (arbiters, interrupt dispatch).

Parameters:
- WIDTH, 8, number of input bits; must be >= 2.
- IDX_W, $clog2(WIDTH), width of the emitted index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  multi-hot input word.
- out_valid  output  1  out_idx/out_last are valid.
- out_ready  input  1  consumer accepts the index.
- out_idx  output  IDX_W  binary index of the current set bit.
- out_last  output  1  out_idx is the last set bit of this word.
- zero_pulse  output  1  one-cycle pulse: an all-zero word was accepted.
- busy  output  1  a word is being scanned.

Behaviour:
- Reset (async, any time, including mid-scan):
  - state=IDLE, pending mask=0.
  - in_ready=1 (from the first cycle after rst deasserts), out_valid=0, out_idx=0, out_last=0, zero_pulse=0, busy=0.
  - Any partially emitted word is discarded.
- States:
  - IDLE: in_ready=1, busy=0, out_valid=0.
  - SCAN: in_ready=0, busy=1, out_valid=1.
- IDLE, on in_valid&&in_ready at edge N:
  - in_data!=0: mask<=in_data, go to SCAN. At N+1, out_idx=lowest set bit and out_last=(popcount==1). One-cycle latency from accept to first out_valid.
  - in_data==0: stay IDLE; zero_pulse=1 during cycle N+1 only. No output beat.
- SCAN, on out_valid&&out_ready:
  - Clear bit out_idx in mask.
  - If out_last=1, go to IDLE; out_valid=0 next cycle and in_ready=1 next cycle. No bypass: the new accept happens at the earliest one cycle after the last beat.
  - Otherwise present the next lowest set bit the following cycle. Back-to-back beats are allowed: one index per cycle when out_ready is held high.
- SCAN with out_ready=0: out_idx and out_last hold stable and out_valid stays 1. No index is dropped or skipped.
- Registered outputs: out_idx and out_last are registered, computed from the next mask. No combinational path from out_ready to out_idx.
- in_valid while in SCAN: ignored; in_data is not sampled.
- Boundaries:
  - All-ones word: WIDTH beats, indices 0..WIDTH-1, out_last on WIDTH-1.
  - Bit WIDTH-1 alone: a single beat with out_idx=WIDTH-1, out_last=1.
  - WIDTH not a power of two: indices never exceed WIDTH-1.

Optional Feature:
- Macro: SEQ_ENC_MSB_FIRST_EN.
- Defined: scan order is descending (highest set bit first); out_last is on the lowest set bit. All handshake and timing rules are unchanged.
- Undefined: ascending order as described above.

Test Plan:
- Reset then in_data=8'b0000_0001 accepted -> one beat, out_idx=0, out_last=1; in_ready=1 on the following cycle.
- in_data=8'b1010_0100, out_ready=1 -> beats out_idx=2,5,7 on consecutive cycles; out_last only on 7. With SEQ_ENC_MSB_FIRST_EN: 7,5,2, out_last on 2.
- in_data=8'hFF with out_ready toggling 1,0,1,0... -> 8 beats 0..7 in order; out_idx stable during every stall cycle; no loss or duplication.
- in_data=8'h00 -> no out_valid; zero_pulse high for exactly one cycle; in_ready stays 1.
- in_data=8'b1100_0000 accepted, rst pulsed after the first beat (idx 6) -> outputs at reset values immediately; no idx 7 is ever emitted; the next word, 8'b0000_1000, yields a single beat idx 3.
- Shift-walk 8'b1<<i for i=0..7 (one word per handshake) -> each yields a single beat out_idx=i, out_last=1. This matches the legacy encoder truth table.
